// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the two-master SRAM-like bus arbiter: transfer sizes,
// grant-FSM states, owner tags and the reset level.
package sram_like_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } gnt_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner tag FIFO (1 bit wide); push and pop take effect on the next edge.
// Full/empty come from the registered count, so a pop frees a slot only next cycle.
module arb_owner_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic                     i_push_dat,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Guard against misuse so the count can never leave 0..DEPTH.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RST_ACTIVE) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= f_nxt(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_nxt(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave SRAM-like arbiter; addr_ok/data_ok routed back with 0 latency.
// A granted request is held locked until addr_ok; slave req drops while the owner FIFO is full.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int RR_EN       = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          inst_req,
    input  logic                          inst_wr,
    input  logic [1:0]                    inst_size,
    input  logic [31:0]                   inst_addr,
    input  logic [31:0]                   inst_wdata,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [31:0]                   inst_rdata,
    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [1:0]                    data_size,
    input  logic [31:0]                   data_addr,
    input  logic [31:0]                   data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [31:0]                   data_rdata,
    output logic                          req,
    output logic                          wr,
    output logic [1:0]                    size,
    output logic [31:0]                   addr,
    output logic [31:0]                   wdata,
    input  logic                          addr_ok,
    input  logic                          data_ok,
    input  logic [31:0]                   rdata,
    output logic [$clog2(OUTSTANDING):0]  outstanding
);

    gnt_state_t r_state;
    gnt_state_t w_state_nxt;
    logic       r_last_data;
    logic       w_rst_act;
    logic       w_gnt_i;
    logic       w_gnt_d;
    logic       w_req;
    logic       w_accept;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_head;

    assign w_rst_act = (resetn == RST_ACTIVE);

    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (RR_EN != 0 && inst_req && data_req) begin
                    w_gnt_d = ~r_last_data;
                    w_gnt_i = r_last_data;
                end else begin
                    w_gnt_d = data_req;
                    w_gnt_i = ~data_req & inst_req;
                end
            end
            LOCK_I:  w_gnt_i = 1'b1;
            LOCK_D:  w_gnt_d = 1'b1;
            default: w_gnt_i = 1'b0;
        endcase
    end

    assign w_req    = ((w_gnt_i & inst_req) | (w_gnt_d & data_req)) & ~w_full & ~w_rst_act;
    assign w_accept = w_req & addr_ok;
    assign w_pop    = data_ok & ~w_empty & ~w_rst_act;

    // A full FIFO forces req low, so neither branch fires and any lock is kept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req && !addr_ok) begin
                    w_state_nxt = w_gnt_d ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I, LOCK_D: begin
                if (w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RST_ACTIVE) begin
            r_state     <= IDLE;
            r_last_data <= OWN_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_data <= w_gnt_d;
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_accept),
        .i_push_dat (w_gnt_d),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head),
        .o_count    (outstanding)
    );

    assign req   = w_req;
    assign wr    = w_gnt_d ? data_wr    : inst_wr;
    assign size  = w_gnt_d ? data_size  : inst_size;
    assign addr  = w_gnt_d ? data_addr  : inst_addr;
    assign wdata = w_gnt_d ? data_wdata : inst_wdata;

    assign inst_addr_ok = w_accept & w_gnt_i;
    assign data_addr_ok = w_accept & w_gnt_d;
    assign inst_data_ok = w_pop & (w_head == OWN_INST);
    assign data_data_ok = w_pop & (w_head == OWN_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: u_fp uses fixed priority, u_rr round-robin, both share stimulus.
// Owner tags are queued at each expected accept and popped on each data_ok.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        inst_addr_ok_0, inst_data_ok_0, data_addr_ok_0, data_data_ok_0;
    logic [31:0] inst_rdata_0, data_rdata_0, addr_0, wdata_0;
    logic        req_0, wr_0;
    logic [1:0]  size_0, outstanding_0;

    logic        inst_addr_ok_1, inst_data_ok_1, data_addr_ok_1, data_data_ok_1;
    logic [31:0] inst_rdata_1, data_rdata_1, addr_1, wdata_1;
    logic        req_1, wr_1;
    logic [1:0]  size_1, outstanding_1;

    int n_cmp = 0;
    int n_err = 0;
    bit q0[$];
    bit q1[$];

    sram_like_arbiter #(.OUTSTANDING(2), .RR_EN(0)) u_fp (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok_0), .inst_data_ok(inst_data_ok_0), .inst_rdata(inst_rdata_0),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_0), .data_data_ok(data_data_ok_0), .data_rdata(data_rdata_0),
        .req(req_0), .wr(wr_0), .size(size_0), .addr(addr_0), .wdata(wdata_0),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .outstanding(outstanding_0)
    );

    sram_like_arbiter #(.OUTSTANDING(2), .RR_EN(1)) u_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok_1), .inst_data_ok(inst_data_ok_1), .inst_rdata(inst_rdata_1),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_1), .data_data_ok(data_data_ok_1), .data_rdata(data_rdata_1),
        .req(req_1), .wr(wr_1), .size(size_1), .addr(addr_1), .wdata(wdata_1),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .outstanding(outstanding_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = SIZE_W; data_addr = 0; data_wdata = 0;
        addr_ok = 0; data_ok = 0; rdata = 0;
    endtask

    // One data_ok pulse on u_fp, checked against the oldest queued owner.
    task automatic drain0(input logic [31:0] rd);
        bit e;
        @(negedge clk);
        data_ok = 1; rdata = rd;
        #1;
        n_cmp++;
        if (q0.size() == 0) begin
            n_err++; $display("FAIL drain0_queue got=empty want=entry");
        end else begin
            e = q0.pop_front();
            if (inst_data_ok_0 !== (e == OWN_INST) || data_data_ok_0 !== (e == OWN_DATA)) begin
                n_err++;
                $display("FAIL drain0_owner got i=%0b d=%0b want owner=%0d", inst_data_ok_0, data_data_ok_0, e);
            end
            n_cmp++;
            if ((e == OWN_INST ? inst_rdata_0 : data_rdata_0) !== rd) begin
                n_err++; $display("FAIL drain0_rdata got=%h want=%h", (e == OWN_INST ? inst_rdata_0 : data_rdata_0), rd);
            end
        end
        @(negedge clk);
        data_ok = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        @(negedge clk); #1;
        n_cmp++;
        if (req_0 !== 1'b0 || outstanding_0 !== 2'd0) begin
            n_err++; $display("FAIL reset_req_cnt got req=%0b cnt=%0d want 0/0", req_0, outstanding_0);
        end
        n_cmp++;
        if ({inst_addr_ok_0, data_addr_ok_0, inst_data_ok_0, data_data_ok_0} !== 4'b0) begin
            n_err++; $display("FAIL reset_strobes got=%b want=0000",
                {inst_addr_ok_0, data_addr_ok_0, inst_data_ok_0, data_data_ok_0});
        end
        @(negedge clk);
        idle_inputs();
        resetn = 1;
    endtask

    task automatic test_priority();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h0000_2000;
        data_req = 1; data_addr = 32'h8000_1000; addr_ok = 1;
        #1;
        n_cmp++;
        if (data_addr_ok_0 !== 1'b1 || inst_addr_ok_0 !== 1'b0 || addr_0 !== 32'h8000_1000) begin
            n_err++; $display("FAIL prio_data_first got d=%0b i=%0b addr=%h want 1/0/80001000",
                data_addr_ok_0, inst_addr_ok_0, addr_0);
        end
        q0.push_back(OWN_DATA);
        @(negedge clk);
        data_req = 0;
        #1;
        n_cmp++;
        if (inst_addr_ok_0 !== 1'b1 || addr_0 !== 32'h0000_2000 || outstanding_0 !== 2'd1) begin
            n_err++; $display("FAIL prio_inst_next got i=%0b addr=%h cnt=%0d want 1/00002000/1",
                inst_addr_ok_0, addr_0, outstanding_0);
        end
        q0.push_back(OWN_INST);
        @(negedge clk);
        inst_req = 0; addr_ok = 0;
        drain0(32'hA1A1_0001);
        drain0(32'hA1A1_0002);
    endtask

    task automatic test_lock();
        @(negedge clk);
        data_req = 1; data_addr = 32'h1FC0_0004; data_size = SIZE_W; data_wdata = 32'hCAFE_0001; data_wr = 1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                inst_req = 1; inst_addr = 32'h0000_3000; inst_size = SIZE_B; inst_wdata = 32'h1111_1111;
            end
            #1;
            n_cmp++;
            if (addr_0 !== 32'h1FC0_0004 || size_0 !== SIZE_W || wdata_0 !== 32'hCAFE_0001 ||
                inst_addr_ok_0 !== 1'b0 || data_addr_ok_0 !== 1'b0 || req_0 !== 1'b1) begin
                n_err++; $display("FAIL lock_data_hold c=%0d got addr=%h size=%0d wdata=%h iok=%0b dok=%0b req=%0b",
                    c, addr_0, size_0, wdata_0, inst_addr_ok_0, data_addr_ok_0, req_0);
            end
            @(negedge clk);
        end
        addr_ok = 1;
        #1;
        n_cmp++;
        if (data_addr_ok_0 !== 1'b1 || inst_addr_ok_0 !== 1'b0) begin
            n_err++; $display("FAIL lock_data_accept got d=%0b i=%0b want 1/0", data_addr_ok_0, inst_addr_ok_0);
        end
        q0.push_back(OWN_DATA);
        // inst now stalls and locks; a late data request must not steal the port.
        @(negedge clk);
        data_req = 0; addr_ok = 0;
        @(negedge clk);
        data_req = 1;
        #1;
        n_cmp++;
        if (addr_0 !== 32'h0000_3000 || data_addr_ok_0 !== 1'b0) begin
            n_err++; $display("FAIL lock_inst_hold got addr=%h dok=%0b want 00003000/0", addr_0, data_addr_ok_0);
        end
        @(negedge clk);
        addr_ok = 1;
        #1;
        n_cmp++;
        if (inst_addr_ok_0 !== 1'b1 || data_addr_ok_0 !== 1'b0) begin
            n_err++; $display("FAIL lock_inst_accept got i=%0b d=%0b want 1/0", inst_addr_ok_0, data_addr_ok_0);
        end
        q0.push_back(OWN_INST);
        @(negedge clk);
        idle_inputs();
        drain0(32'hB2B2_0001);
        drain0(32'hB2B2_0002);
    endtask

    task automatic test_full_and_overlap();
        bit e;
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h0000_0100; addr_ok = 1;
        #1; q0.push_back(OWN_INST);
        @(negedge clk);
        inst_req = 0; data_req = 1; data_addr = 32'h0000_0200;
        #1; q0.push_back(OWN_DATA);
        @(negedge clk);
        data_req = 0; inst_req = 1; inst_addr = 32'h0000_0104;
        #1;
        n_cmp++;
        if (req_0 !== 1'b0 || inst_addr_ok_0 !== 1'b0 || outstanding_0 !== 2'd2) begin
            n_err++; $display("FAIL full_block got req=%0b iok=%0b cnt=%0d want 0/0/2", req_0, inst_addr_ok_0, outstanding_0);
        end
        @(negedge clk);
        data_ok = 1; rdata = 32'h1234_5678;
        #1;
        e = q0.pop_front();
        n_cmp++;
        if (req_0 !== 1'b0 || inst_data_ok_0 !== (e == OWN_INST) || data_data_ok_0 !== (e == OWN_DATA) ||
            inst_rdata_0 !== 32'h1234_5678) begin
            n_err++; $display("FAIL full_pop1 got req=%0b i=%0b d=%0b rd=%h want 0/owner%0d/12345678",
                req_0, inst_data_ok_0, data_data_ok_0, inst_rdata_0, e);
        end
        @(negedge clk);
        rdata = 32'h0BAD_F00D;
        #1;
        e = q0.pop_front();
        n_cmp++;
        if (data_data_ok_0 !== (e == OWN_DATA) || inst_data_ok_0 !== (e == OWN_INST) ||
            data_rdata_0 !== 32'h0BAD_F00D || req_0 !== 1'b1 || inst_addr_ok_0 !== 1'b1) begin
            n_err++; $display("FAIL full_pop2 got d=%0b i=%0b rd=%h req=%0b iok=%0b want owner%0d/0badf00d/1/1",
                data_data_ok_0, inst_data_ok_0, data_rdata_0, req_0, inst_addr_ok_0, e);
        end
        q0.push_back(OWN_INST);
        @(negedge clk);
        inst_req = 0; data_req = 1; data_addr = 32'h0000_0300; rdata = 32'h0000_0044;
        #1;
        e = q0.pop_front();
        n_cmp++;
        if (outstanding_0 !== 2'd1 || inst_data_ok_0 !== (e == OWN_INST) ||
            data_data_ok_0 !== (e == OWN_DATA) || data_addr_ok_0 !== 1'b1) begin
            n_err++; $display("FAIL overlap got cnt=%0d i=%0b d=%0b dok=%0b want 1/owner%0d/1",
                outstanding_0, inst_data_ok_0, data_data_ok_0, data_addr_ok_0, e);
        end
        q0.push_back(OWN_DATA);
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (outstanding_0 !== 2'd1) begin
            n_err++; $display("FAIL overlap_cnt got=%0d want=1", outstanding_0);
        end
        drain0(32'h0000_0055);
        #1;
        n_cmp++;
        if (outstanding_0 !== 2'd0) begin
            n_err++; $display("FAIL drained_cnt got=%0d want=0", outstanding_0);
        end
    endtask

    task automatic test_round_robin();
        bit last = OWN_INST;
        bit exp_d;
        bit e;
        int n_d = 0;
        int n_i = 0;
        @(negedge clk);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        q0.delete(); q1.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1; rdata = 32'hC0DE_0000 + k;
            #1;
            exp_d = (last == OWN_INST);
            n_cmp++;
            if (data_addr_ok_1 !== exp_d || inst_addr_ok_1 !== !exp_d || data_addr_ok_0 !== 1'b1) begin
                n_err++; $display("FAIL rr_grant k=%0d got rr d=%0b i=%0b fp d=%0b want rr d=%0b fp d=1",
                    k, data_addr_ok_1, inst_addr_ok_1, data_addr_ok_0, exp_d);
            end
            n_cmp++;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                if (data_data_ok_1 !== (e == OWN_DATA) || inst_data_ok_1 !== (e == OWN_INST)) begin
                    n_err++; $display("FAIL rr_resp k=%0d got d=%0b i=%0b want owner%0d", k, data_data_ok_1, inst_data_ok_1, e);
                end
            end else if (data_data_ok_1 !== 1'b0 || inst_data_ok_1 !== 1'b0) begin
                n_err++; $display("FAIL rr_stale k=%0d got d=%0b i=%0b want 0/0", k, data_data_ok_1, inst_data_ok_1);
            end
            q1.push_back(exp_d ? OWN_DATA : OWN_INST);
            if (data_addr_ok_1) n_d++;
            else if (inst_addr_ok_1) n_i++;
            last = exp_d ? OWN_DATA : OWN_INST;
        end
        n_cmp++;
        if (n_d != 2 || n_i != 2) begin
            n_err++; $display("FAIL rr_balance got d=%0d i=%0d want 2/2", n_d, n_i);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        q0.delete();
        @(negedge clk);
        inst_req = 1; inst_addr = 32'h0000_0400; addr_ok = 1;
        #1;
        n_cmp++;
        if (inst_addr_ok_0 !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_accept got=%0b want=1", inst_addr_ok_0);
        end
        @(negedge clk);
        addr_ok = 0;
        #1;
        n_cmp++;
        if (outstanding_0 !== 2'd1) begin
            n_err++; $display("FAIL rst_mid_cnt got=%0d want=1", outstanding_0);
        end
        resetn = 0; addr_ok = 1;
        #1;
        n_cmp++;
        if (req_0 !== 1'b0 || outstanding_0 !== 2'd0 || inst_addr_ok_0 !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_held got req=%0b cnt=%0d iok=%0b want 0/0/0", req_0, outstanding_0, inst_addr_ok_0);
        end
        @(negedge clk);
        resetn = 1; inst_req = 0; addr_ok = 0;
        @(negedge clk);
        data_ok = 1; rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (inst_data_ok_0 !== 1'b0 || data_data_ok_0 !== 1'b0 || outstanding_0 !== 2'd0) begin
            n_err++; $display("FAIL rst_mid_stale got i=%0b d=%0b cnt=%0d want 0/0/0",
                inst_data_ok_0, data_data_ok_0, outstanding_0);
        end
        @(negedge clk);
        data_ok = 0;
        #1;
        n_cmp++;
        if (outstanding_0 !== 2'd0) begin
            n_err++; $display("FAIL rst_mid_after got=%0d want=0", outstanding_0);
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        test_reset();
        test_priority();
        test_lock();
        test_full_and_overlap();
        test_round_robin();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
